// File: rtl/milano_pkg.sv
// ---------------------------------------------------------------------------
// milano_pkg
// Shared types for the execute stage: the ALU operator encoding, the output
// stage state of the ALU arbiter, requester indices and a small helper that
// turns a requester index into a one-hot grant vector.
// ---------------------------------------------------------------------------
package milano_pkg;

    localparam int ALU_OP_W    = 3;
    localparam int ARB_NUM_REQ = 2;

    localparam logic REQ_R0 = 1'b0;
    localparam logic REQ_R1 = 1'b1;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_opt_e;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } alu_arb_state_e;

    // Requester index to one-hot grant (bit k = rk).
    function automatic logic [ARB_NUM_REQ-1:0] req_onehot(input logic idx);
        return (idx == REQ_R1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Single-cycle combinational ALU. Only ADD and SUB are implemented; any other
// operator returns 0 with reg_we_o=0 so the caller can flag it as illegal.
// Ports:
//   op_i      operator
//   a_i, b_i  32-bit operands
//   rd_i      destination register, passed through to wr_addr_o
//   result_o  32-bit wrap-around result
//   wr_addr_o destination register
//   reg_we_o  1 when the operator is supported
// ---------------------------------------------------------------------------
module alu
    import milano_pkg::*;
(
    input  alu_opt_e    op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  rd_i,
    output logic [31:0] result_o,
    output logic [4:0]  wr_addr_o,
    output logic        reg_we_o
);

    // Unsupported operators fall through to a zero result without a write.
    always_comb begin
        result_o = 32'd0;
        reg_we_o = 1'b0;
        case (op_i)
            ALU_ADD: begin
                result_o = a_i + b_i;
                reg_we_o = 1'b1;
            end
            ALU_SUB: begin
                result_o = a_i - b_i;
                reg_we_o = 1'b1;
            end
            default: begin
                result_o = 32'd0;
                reg_we_o = 1'b0;
            end
        endcase
    end

    assign wr_addr_o = rd_i;

endmodule

// File: rtl/alu_arb_rr2.sv
// ---------------------------------------------------------------------------
// alu_arb_rr2
// Two-way grant logic for the ALU arbiter. Grant is combinational from the
// request valids; last_grant and the r1 starvation counter update only when
// the granted request is actually accepted.
// Parameters:
//   PRIO_FIXED   0 = round-robin, 1 = r0 priority with anti-starvation
//   STARVE_LIMIT consecutive r1 losses before r1 is forced through (1..15)
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   req_valid_i    per-requester valid
//   accept_i       the granted request transfers this cycle
//   grant_o        one-hot grant (r0 when nobody is valid)
// ---------------------------------------------------------------------------
module alu_arb_rr2
    import milano_pkg::*;
#(
    parameter int PRIO_FIXED   = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_valid_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic       last_grant;
    logic [3:0] starve_cnt;
    logic       starved;

    assign starved = (starve_cnt == 4'(STARVE_LIMIT));

    // With both requesters valid, round-robin hands the grant to whoever did
    // not win last; fixed priority favours r0 until r1 has been starved long
    // enough. With nobody valid r0 is the default grant.
    always_comb begin
        grant_o = req_onehot(REQ_R0);
        case (req_valid_i)
            2'b01:   grant_o = req_onehot(REQ_R0);
            2'b10:   grant_o = req_onehot(REQ_R1);
            2'b11: begin
                if (PRIO_FIXED != 0) begin
                    grant_o = req_onehot(starved);
                end else begin
                    grant_o = req_onehot(~last_grant);
                end
            end
            default: grant_o = req_onehot(REQ_R0);
        endcase
    end

    // last_grant starts at r1 so r0 wins the first contested cycle. The
    // starvation counter clears when r1 gets through and saturates at the
    // limit while r1 keeps waiting behind accepted r0 requests.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant <= REQ_R1;
            starve_cnt <= 4'd0;
        end else if (accept_i) begin
            last_grant <= grant_o[1];
            if (grant_o[1]) begin
                starve_cnt <= 4'd0;
            end else if (req_valid_i[1] && !starved) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between r0 (main issue) and r1 (secondary path). Arbitrates,
// launches the selected operation and registers the result in a one-entry
// output stage with valid/ready; the register-file write port fires on the
// result handoff.
// Optional feature: define MILANO_ALU_ARB_PERF_EN to build the performance
// counters; otherwise perf_* are tied to 0.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o     per-requester handshake (bit k = rk)
//   req_op_i, req_a_i, req_b_i    per-requester operator and operands
//   req_rd_i                      per-requester destination register
//   res_valid_o / res_ready_i     output stage handshake
//   res_data_o, res_owner_o       held result and issuing requester
//   res_illegal_o                 held op was not ADD/SUB
//   rf_we_o, rf_waddr_o, rf_wdata_o register-file write port
//   perf_grant0_o/1_o, perf_stall_o optional saturating counters
// ---------------------------------------------------------------------------
module alu_arbiter
    import milano_pkg::*;
#(
    parameter int PRIO_FIXED   = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [1:0]                req_valid_i,
    output logic [1:0]                req_ready_o,
    input  logic [1:0][ALU_OP_W-1:0]  req_op_i,
    input  logic [1:0][31:0]          req_a_i,
    input  logic [1:0][31:0]          req_b_i,
    input  logic [1:0][4:0]           req_rd_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [31:0]               res_data_o,
    output logic                      res_owner_o,
    output logic                      res_illegal_o,
    output logic                      rf_we_o,
    output logic [4:0]                rf_waddr_o,
    output logic [31:0]               rf_wdata_o,
    output logic [31:0]               perf_grant0_o,
    output logic [31:0]               perf_grant1_o,
    output logic [31:0]               perf_stall_o
);

    alu_arb_state_e state;
    logic [1:0]     grant;
    logic           sel;
    logic           can_accept;
    logic           accept;
    logic [31:0]    alu_result;
    logic [4:0]     alu_waddr;
    logic           alu_we;
    logic [4:0]     res_rd;

    assign can_accept  = (state == ARB_EMPTY) | res_ready_i;
    assign req_ready_o = grant & {2{can_accept}};
    assign accept      = |(req_valid_i & req_ready_o);
    assign sel         = grant[1];

    alu_arb_rr2 #(
        .PRIO_FIXED   (PRIO_FIXED),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_rr2 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .accept_i    (accept),
        .grant_o     (grant)
    );

    alu u_alu (
        .op_i      (alu_opt_e'(req_op_i[sel])),
        .a_i       (req_a_i[sel]),
        .b_i       (req_b_i[sel]),
        .rd_i      (req_rd_i[sel]),
        .result_o  (alu_result),
        .wr_addr_o (alu_waddr),
        .reg_we_o  (alu_we)
    );

    // One-entry output stage. An accept always (re)fills the stage, which
    // covers back-to-back drain+accept; a drain without a new accept empties
    // it. While FULL and stalled nothing can be accepted, so the held result
    // stays put.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= ARB_EMPTY;
            res_data_o    <= 32'd0;
            res_owner_o   <= REQ_R0;
            res_illegal_o <= 1'b0;
            res_rd        <= 5'd0;
        end else if (accept) begin
            state         <= ARB_FULL;
            res_data_o    <= alu_result;
            res_owner_o   <= sel;
            res_illegal_o <= ~alu_we;
            res_rd        <= alu_waddr;
        end else if ((state == ARB_FULL) && res_ready_i) begin
            state         <= ARB_EMPTY;
        end
    end

    assign res_valid_o = (state == ARB_FULL);

    // The register file sees a write only on a legal result's handoff;
    // writes to x0 are passed on and ignored by the register file.
    assign rf_we_o    = res_valid_o & res_ready_i & ~res_illegal_o;
    assign rf_waddr_o = res_rd;
    assign rf_wdata_o = res_data_o;

`ifdef MILANO_ALU_ARB_PERF_EN
    logic [31:0] grant0_cnt;
    logic [31:0] grant1_cnt;
    logic [31:0] stall_cnt;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant0_cnt <= 32'd0;
            grant1_cnt <= 32'd0;
            stall_cnt  <= 32'd0;
        end else begin
            if (accept && !sel && (grant0_cnt != 32'hFFFF_FFFF)) begin
                grant0_cnt <= grant0_cnt + 32'd1;
            end
            if (accept && sel && (grant1_cnt != 32'hFFFF_FFFF)) begin
                grant1_cnt <= grant1_cnt + 32'd1;
            end
            if (res_valid_o && !res_ready_i && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_grant0_o = grant0_cnt;
    assign perf_grant1_o = grant1_cnt;
    assign perf_stall_o  = stall_cnt;
`else
    assign perf_grant0_o = 32'd0;
    assign perf_grant1_o = 32'd0;
    assign perf_stall_o  = 32'd0;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational alu between two requesters: r0 (main issue path) and r1 (secondary path, e.g. address/branch helper).
- Arbitrates, launches the operation, and registers the result in a one-entry output stage with a valid/ready handshake.
- Drives the register-file write port on result handoff.
- Sits in the execute stage between decode/issue and writeback.

Parameters:
- PRIO_FIXED, 0, 0 = round-robin between r0/r1; 1 = r0 has fixed priority with anti-starvation.
- STARVE_LIMIT, 4, applies when PRIO_FIXED=1. After this many consecutive cycles in which r1 is valid and loses, r1 is granted next. Range 1..15.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  2  per-requester request valid; bit k = rk
- req_ready_o  out  2  per-requester accept; transfer when valid&ready
- req_op_i  in  2 x milano_pkg::alu_opt_e  operator per requester
- req_a_i  in  2x32  operand A per requester
- req_b_i  in  2x32  operand B per requester
- req_rd_i  in  2x5  destination register per requester
- res_valid_o  out  1  output stage holds a result
- res_ready_i  in  1  consumer accepts result
- res_data_o  out  32  registered ALU result
- res_owner_o  out  1  requester that issued the held result
- res_illegal_o  out  1  held op was not ALU_ADD/ALU_SUB
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  32  register-file write data
- perf_grant0_o  out  32  optional counter
- perf_grant1_o  out  32  optional counter
- perf_stall_o  out  32  optional counter

Behaviour:
- Reset (async assert, sync deassert usage): res_valid_o=0, res_data_o=0, res_owner_o=0, res_illegal_o=0, rf_* = 0, perf_* = 0. last_grant=1, so r0 wins first. Starve counter = 0.
- FSM of the output stage (milano_pkg::alu_arb_state_e):
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on res_ready_i with no new accept.
  - FULL -> FULL on drain and accept in the same cycle (back-to-back).
- can_accept = (state==EMPTY) | res_ready_i.
- Grant logic is combinational from req_valid_i:
  - Only one requester valid: it wins.
  - Both valid, round-robin: the requester not equal to last_grant wins.
  - Both valid, fixed: r0 wins unless starve_cnt == STARVE_LIMIT, then r1 wins.
- req_ready_o[k] = grant[k] & can_accept. At most one bit is set. A ready bit may be high without valid only when that requester is the sole default grant; valid does not depend on ready.
- On accept (edge k):
  - Capture alu outputs for rk's operands into the stage: data, wr_addr, we.
  - res_owner_o=k; res_illegal_o = ~alu reg_we.
  - last_grant=k. Starve counter clears on an r1 grant, increments (saturating) when r1 is valid and not granted.
- Latency: result visible exactly one cycle after the accepting edge; throughput one op/cycle while res_ready_i=1.
- Writeback:
  - rf_we_o = res_valid_o & res_ready_i & ~res_illegal_o, combinational.
  - rf_waddr_o/rf_wdata_o mirror the stage.
  - Writes to x0 pass through unchanged (the register file ignores them).
- Illegal op: alu returns 0 with we=0. The result is still handed off with res_illegal_o=1 and never writes the register file.
- Holding: while FULL and res_ready_i=0, all res_* outputs are stable and req_ready_o=0.
- Arithmetic: 32-bit wrap-around, e.g. 0xFFFFFFFF+1 = 0.
- Reset mid-operation: the held result is discarded and no rf write occurs.

Optional Feature:
- MILANO_ALU_ARB_PERF_EN defined:
  - perf_grant0_o / perf_grant1_o count accepts per requester.
  - perf_stall_o counts cycles with res_valid_o & ~res_ready_i.
  - All three are 32-bit saturating counters, cleared only by reset.
- Undefined: the three ports are tied to 0 and no counter flops exist.

Decomposition:
- milano_pkg gains:
  - alu_arb_state_e {ARB_EMPTY, ARB_FULL}
  - REQ_R0=1'b0, REQ_R1=1'b1
  - ARB_NUM_REQ=2
- alu_opt_e is reused from milano_pkg.
- Instantiate the existing alu once on the grant-muxed operands.
- Natural sub-module: alu_arb_rr2, containing the grant logic, last_grant and starve counter.

Test Plan:
1. Reset, then r0 valid with ADD 5+7 rd=3, res_ready_i=1 -> req_ready_o=01. Next cycle res_data_o=12, owner=0, rf_we_o=1, rf_waddr_o=3.
2. Both valid every cycle, PRIO_FIXED=0, res_ready_i=1 -> grants alternate r0,r1,r0,r1. Four results in four cycles with owners 0,1,0,1.
3. PRIO_FIXED=1, STARVE_LIMIT=4, both always valid -> r0 wins four times, r1 wins the fifth, and the pattern repeats.
4. FULL with res_ready_i=0 for 3 cycles -> req_ready_o=00 and outputs stable. Raising ready drains the stage and accepts the next request in the same cycle.
5. r1 SUB 0x0-0x1 -> res_data_o=0xFFFFFFFF. An unsupported op gives res_illegal_o=1, res_data_o=0, rf_we_o=0.
6. Assert rst_ni low while FULL -> res_valid_o=0 immediately. No rf write. Perf counters are 0 with MILANO_ALU_ARB_PERF_EN.
